fruit_spawn_scheduler: RTL

FRUIT_SPAWN_SCHEDULER -- requirements
Module: fruit_spawn_scheduler

---
 rtl/fruit_spawn_scheduler.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/fruit_spawn_scheduler.sv
// Fruit spawn scheduler: paces fruit launches into shared motion slots, tracks
// cuts (score) and fruits lost off-screen (misses), and ends the game on too many misses.
module fruit_spawn_scheduler #(
  parameter int NUM_SLOTS  = 4,
  parameter int MIN_GAP    = 8,
  parameter int MAX_MISSES = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_tick,
  input  logic                 game_active,
  input  logic                 cut_valid,
  input  logic [1:0]           cut_slot,
  input  logic [NUM_SLOTS-1:0] offscreen,
  input  logic                 spawn_ready,
  output logic                 spawn_valid,
  output logic [1:0]           spawn_slot,
  output logic [9:0]           spawn_x,
  output logic [NUM_SLOTS-1:0] slot_active,
  output logic [5:0]           number_of_fruits_cut,
  output logic [1:0]           misses,
  output logic                 GG
);

  localparam int CW = $clog2(MIN_GAP + 32) + 1;

  typedef enum logic [1:0] {IDLE, COUNTDOWN, REQUEST, OVER} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        gap_q, gap_d;
  logic [15:0]          lfsr_q, lfsr_d;
  logic                 ga_q;
  logic [NUM_SLOTS-1:0] slot_active_q, slot_active_d;
  logic [5:0]           score_q, score_d;
  logic [1:0]           misses_q, misses_d;
  logic                 gg_q, gg_d;
  logic [1:0]           spawn_slot_q, spawn_slot_d;
  logic [9:0]           spawn_x_q, spawn_x_d;

  logic                 free_any;
  logic [1:0]           free_idx;
  logic                 cut_hit;
  logic [3:0]           miss_cnt;
  logic [NUM_SLOTS-1:0] act;

  function automatic logic [5:0] sat_score(input logic [5:0] s);
    return (s == 6'd63) ? s : s + 6'd1;
  endfunction

  function automatic logic [1:0] sat_misses(input logic [1:0] m, input logic [3:0] n);
    logic [4:0] sum;
    sum = {3'b000, m} + {1'b0, n};
    return (sum > 5'd3) ? 2'd3 : sum[1:0];
  endfunction

  // Lowest-index free slot, judged on the registered occupancy
  always_comb begin
    free_any = 1'b0;
    free_idx = 2'd0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
      if (!slot_active_q[i]) begin
        free_any = 1'b1;
        free_idx = 2'(i);
      end
    end
  end

  assign cut_hit = cut_valid && slot_active_q[cut_slot];

  always_comb begin
    state_d       = state_q;
    gap_d         = gap_q;
    lfsr_d        = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    slot_active_d = slot_active_q;
    score_d       = score_q;
    misses_d      = misses_q;
    gg_d          = gg_q;
    spawn_slot_d  = spawn_slot_q;
    spawn_x_d     = spawn_x_q;
    act           = slot_active_q;
    miss_cnt      = 4'd0;

    case (state_q)
      IDLE: begin
        if (game_active && !ga_q) begin
          score_d       = '0;
          misses_d      = '0;
          gg_d          = 1'b0;
          slot_active_d = '0;
          gap_d         = CW'(MIN_GAP);
          state_d       = COUNTDOWN;
        end
      end
      COUNTDOWN, REQUEST: begin
        if (cut_hit) begin
          act[cut_slot] = 1'b0;
          score_d       = sat_score(score_q);
        end
        // A cut on the same slot takes precedence over its off-screen miss
        for (int i = 0; i < NUM_SLOTS; i++) begin
          if (slot_active_q[i] && offscreen[i] && !(cut_hit && (int'(cut_slot) == i))) begin
            act[i]   = 1'b0;
            miss_cnt = miss_cnt + 4'd1;
          end
        end
        misses_d = sat_misses(misses_q, miss_cnt);

        if (state_q == COUNTDOWN) begin
          if (gap_q != '0) begin
            if (frame_tick) gap_d = gap_q - CW'(1);
          end else if (free_any) begin
            state_d      = REQUEST;
            spawn_slot_d = free_idx;
            spawn_x_d    = 10'd64 + 10'(lfsr_q[8:0]);
          end
        end else if (spawn_ready) begin
          act[spawn_slot_q] = 1'b1;
          gap_d             = CW'(MIN_GAP) + CW'(lfsr_q[4:0]);
          state_d           = COUNTDOWN;
        end
        slot_active_d = act;

        if (int'(misses_d) >= MAX_MISSES) begin
          state_d       = OVER;
          gg_d          = 1'b1;
          slot_active_d = '0;
        end
      end
      default: ;
    endcase

    if (!game_active) begin
      state_d       = IDLE;
      slot_active_d = '0;
      score_d       = score_q;
      misses_d      = misses_q;
      gg_d          = gg_q;
      gap_d         = gap_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      gap_q         <= '0;
      lfsr_q        <= 16'hACE1;
      ga_q          <= 1'b0;
      slot_active_q <= '0;
      score_q       <= '0;
      misses_q      <= '0;
      gg_q          <= 1'b0;
      spawn_slot_q  <= '0;
      spawn_x_q     <= '0;
    end else begin
      state_q       <= state_d;
      gap_q         <= gap_d;
      lfsr_q        <= lfsr_d;
      ga_q          <= game_active;
      slot_active_q <= slot_active_d;
      score_q       <= score_d;
      misses_q      <= misses_d;
      gg_q          <= gg_d;
      spawn_slot_q  <= spawn_slot_d;
      spawn_x_q     <= spawn_x_d;
    end
  end

  assign spawn_valid          = (state_q == REQUEST);
  assign spawn_slot           = spawn_slot_q;
  assign spawn_x              = spawn_x_q;
  assign slot_active          = slot_active_q;
  assign number_of_fruits_cut = score_q;
  assign misses               = misses_q;
  assign GG                   = gg_q;

endmodule
